// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: pipeline writeback, multi-cycle result
// queue handshake, decode hazard query and the registered register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    // MC_Valid/MC_Ready: a result transfers in any cycle where both are high. MC_Ready never
    // depends on MC_Valid or on a pop in the same cycle. A source that raises MC_Valid holds
    // MC_Rd/MC_Data stable until the transfer completes.
    logic                     WB_RegWrite;
    logic [4:0]               WB_RtRd;
    logic [31:0]              WB_WriteData;
    logic                     MC_Valid;
    logic [4:0]               MC_Rd;
    logic [31:0]              MC_Data;
    logic                     MC_Ready;
    logic [4:0]               ID_Rs;
    logic [4:0]               ID_Rt;
    logic                     ID_PendHazard;
    logic                     Pipe_Hold;
    logic                     RF_WE;
    logic [4:0]               RF_Addr;
    logic [31:0]              RF_Data;
    logic [$clog2(DEPTH):0]   Q_Count;

    modport slave (
        input  WB_RegWrite, WB_RtRd, WB_WriteData,
        input  MC_Valid, MC_Rd, MC_Data,
        input  ID_Rs, ID_Rt,
        output MC_Ready, ID_PendHazard, Pipe_Hold,
        output RF_WE, RF_Addr, RF_Data, Q_Count
    );

    modport master (
        output WB_RegWrite, WB_RtRd, WB_WriteData,
        output MC_Valid, MC_Rd, MC_Data,
        output ID_Rs, ID_Rt,
        input  MC_Ready, ID_PendHazard, Pipe_Hold,
        input  RF_WE, RF_Addr, RF_Data, Q_Count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, a small in-order queue of
// multi-cycle results drains in idle cycles. Optional WBARB_PERF_EN adds performance counters.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
`ifdef WBARB_PERF_EN
    ,
    output logic [31:0]          Perf_HoldCycles,
    output logic [31:0]          Perf_KillCount
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_occ;
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [7:0]       r_starve;
    logic             r_hold;
    logic             r_we;
    logic [4:0]       r_addr;
    logic [31:0]      r_wdata;

    logic             w_wb_grant;
    logic             w_head_occ;
    logic             w_head_live;
    logic             w_q_grant;
    logic             w_pop;
    logic             w_ready;
    logic             w_push;
    logic             w_hazard;
    logic [DEPTH-1:0] w_kill;
    logic [7:0]       w_starve_next;
    logic             w_hold_next;

    always_comb begin
        w_wb_grant  = bus.WB_RegWrite && (bus.WB_RtRd != 5'd0);
        w_head_occ  = r_occ[r_head];
        w_head_live = w_head_occ && r_live[r_head];
        w_q_grant   = !w_wb_grant && w_head_live;
        // A killed head leaves without a write so it never blocks younger results.
        w_pop       = w_q_grant || (w_head_occ && !r_live[r_head]);
        w_ready     = (r_count < CW'(DEPTH));
        w_push      = bus.MC_Valid && w_ready && (bus.MC_Rd != 5'd0);
    end

    always_comb begin
        w_hazard = 1'b0;
        w_kill   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_occ[i] && r_live[i] &&
                ((bus.ID_Rs != 5'd0 && r_rd[i] == bus.ID_Rs) ||
                 (bus.ID_Rt != 5'd0 && r_rd[i] == bus.ID_Rt)))
                w_hazard = 1'b1;
            w_kill[i] = w_wb_grant && r_occ[i] && r_live[i] && (r_rd[i] == bus.WB_RtRd);
        end
        if (w_push && ((bus.ID_Rs != 5'd0 && bus.MC_Rd == bus.ID_Rs) ||
                       (bus.ID_Rt != 5'd0 && bus.MC_Rd == bus.ID_Rt)))
            w_hazard = 1'b1;
    end

    always_comb begin
        if (!w_head_live || w_q_grant)
            w_starve_next = 8'd0;
        else if (r_starve == 8'hFF)
            w_starve_next = 8'hFF;
        else
            w_starve_next = r_starve + 8'd1;
        w_hold_next = w_head_live && (w_starve_next >= 8'(STARVE_LIMIT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_occ    <= '0;
            r_live   <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_hold   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= w_wb_grant || w_q_grant;
            if (w_wb_grant) begin
                r_addr  <= bus.WB_RtRd;
                r_wdata <= bus.WB_WriteData;
            end else if (w_q_grant) begin
                r_addr  <= r_rd[r_head];
                r_wdata <= r_data[r_head];
            end

            // The entry being pushed is younger than the WB write, so it is never killed.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && r_tail == AW'(i)) begin
                    r_occ[i]  <= 1'b1;
                    r_live[i] <= 1'b1;
                    r_rd[i]   <= bus.MC_Rd;
                    r_data[i] <= bus.MC_Data;
                end else if (w_pop && r_head == AW'(i)) begin
                    r_occ[i]  <= 1'b0;
                    r_live[i] <= 1'b0;
                end else if (w_kill[i]) begin
                    r_live[i] <= 1'b0;
                end
            end

            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            r_starve <= w_starve_next;
            r_hold   <= w_hold_next;
        end
    end

    assign bus.MC_Ready      = w_ready;
    assign bus.ID_PendHazard = w_hazard;
    assign bus.Pipe_Hold     = r_hold;
    assign bus.RF_WE         = r_we;
    assign bus.RF_Addr       = r_addr;
    assign bus.RF_Data       = r_wdata;
    assign bus.Q_Count       = r_count;

`ifdef WBARB_PERF_EN
    logic [31:0] r_perf_hold;
    logic [31:0] r_perf_kill;
    logic [31:0] w_kill_num;

    always_comb begin
        w_kill_num = '0;
        for (int i = 0; i < DEPTH; i++)
            w_kill_num = w_kill_num + 32'(w_kill[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_hold <= '0;
            r_perf_kill <= '0;
        end else begin
            if (r_hold) r_perf_hold <= r_perf_hold + 32'd1;
            r_perf_kill <= r_perf_kill + w_kill_num;
        end
    end

    assign Perf_HoldCycles = r_perf_hold;
    assign Perf_KillCount  = r_perf_kill;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table for single-cycle behaviour, hand
// sequences for starvation/hold and asynchronous reset; every RF write goes through exp_q.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus();

`ifdef WBARB_PERF_EN
    logic [31:0] perf_hold;
    logic [31:0] perf_kill;
`endif

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef WBARB_PERF_EN
        ,
        .Perf_HoldCycles (perf_hold),
        .Perf_KillCount  (perf_kill)
`endif
    );

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mc_v;
        logic [4:0]  mc_rd;
        logic [31:0] mc_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        exp_ready;
        logic        exp_haz;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [2:0]  exp_count;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    logic [36:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic e_rdy, input logic e_haz, input logic e_we,
                                input logic [4:0] e_addr, input logic [31:0] e_data,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.wb_we = we; v.wb_rd = wrd; v.wb_data = wd;
        v.mc_v = mv; v.mc_rd = mrd; v.mc_data = md;
        v.rs = rs; v.rt = rt;
        v.exp_ready = e_rdy; v.exp_haz = e_haz; v.exp_we = e_we;
        v.exp_addr = e_addr; v.exp_data = e_data; v.exp_count = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.WB_RegWrite  = we;
        bus.WB_RtRd      = wrd;
        bus.WB_WriteData = wd;
        bus.MC_Valid     = mv;
        bus.MC_Rd        = mrd;
        bus.MC_Data      = md;
        bus.ID_Rs        = rs;
        bus.ID_Rt        = rt;
    endtask

    // Write monitor: every registered write must match the oldest expected write.
    always @(negedge clock) begin
        logic [36:0] e;
        if (!reset && bus.RF_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, bus.RF_Addr, bus.RF_Data}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rf_write", {27'd0, bus.RF_Addr, bus.RF_Data}, {27'd0, e});
            end
        end
    end

    initial begin
        vt[0]  = mk(0, 0, 0,           1, 5, 32'hA5A5A5A5, 5, 0,  1, 1, 0, 0, 0,            1);
        vt[1]  = mk(0, 0, 0,           0, 0, 0,            5, 0,  1, 1, 1, 5, 32'hA5A5A5A5, 0);
        vt[2]  = mk(0, 0, 0,           0, 0, 0,            5, 0,  1, 0, 0, 0, 0,            0);
        vt[3]  = mk(0, 0, 0,           1, 0, 32'h1234,     0, 0,  1, 0, 0, 0, 0,            0);
        vt[4]  = mk(1, 0, 32'h99,      1, 12, 32'hC0,      0, 12, 1, 1, 0, 0, 0,            1);
        vt[5]  = mk(1, 0, 32'h99,      0, 0, 0,            0, 12, 1, 1, 1, 12, 32'hC0,      0);
        vt[6]  = mk(1, 4, 32'h44,      1, 4, 32'h55,       4, 0,  1, 1, 1, 4, 32'h44,       1);
        vt[7]  = mk(0, 0, 0,           0, 0, 0,            4, 0,  1, 1, 1, 4, 32'h55,       0);
        vt[8]  = mk(0, 0, 0,           1, 3, 32'h33,       3, 0,  1, 1, 0, 0, 0,            1);
        vt[9]  = mk(1, 3, 32'h300,     0, 0, 0,            3, 0,  1, 1, 1, 3, 32'h300,      1);
        vt[10] = mk(0, 0, 0,           0, 0, 0,            3, 0,  1, 0, 0, 0, 0,            0);
        vt[11] = mk(0, 0, 0,           0, 0, 0,            0, 3,  1, 0, 0, 0, 0,            0);
        vt[12] = mk(0, 0, 0,           1, 1, 32'h11,       0, 0,  1, 0, 0, 0, 0,            1);
        vt[13] = mk(1, 31, 32'hF1,     1, 2, 32'h22,       0, 0,  1, 0, 1, 31, 32'hF1,      2);
        vt[14] = mk(1, 31, 32'hF2,     1, 6, 32'h66,       0, 0,  1, 0, 1, 31, 32'hF2,      3);
        vt[15] = mk(1, 31, 32'hF3,     1, 7, 32'h77,       0, 7,  1, 1, 1, 31, 32'hF3,      4);
        vt[16] = mk(1, 31, 32'hF4,     1, 8, 32'h88,       8, 0,  0, 0, 1, 31, 32'hF4,      4);
        vt[17] = mk(0, 0, 0,           1, 9, 32'h99,       9, 0,  0, 0, 1, 1, 32'h11,       3);
        vt[18] = mk(0, 0, 0,           1, 8, 32'h88,       0, 0,  1, 0, 1, 2, 32'h22,       3);
        vt[19] = mk(0, 0, 0,           0, 0, 0,            6, 0,  1, 1, 1, 6, 32'h66,       2);
        vt[20] = mk(0, 0, 0,           0, 0, 0,            0, 0,  1, 0, 1, 7, 32'h77,       1);
        vt[21] = mk(0, 0, 0,           0, 0, 0,            8, 0,  1, 1, 1, 8, 32'h88,       0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        check("rst_rf_we",   bus.RF_WE, 0);
        check("rst_rf_addr", bus.RF_Addr, 0);
        check("rst_rf_data", bus.RF_Data, 0);
        check("rst_q_count", bus.Q_Count, 0);
        check("rst_hold",    bus.Pipe_Hold, 0);
        check("rst_ready",   bus.MC_Ready, 1);
        check("rst_hazard",  bus.ID_PendHazard, 0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].wb_we, vt[i].wb_rd, vt[i].wb_data, vt[i].mc_v, vt[i].mc_rd,
                  vt[i].mc_data, vt[i].rs, vt[i].rt);
            #1;
            check($sformatf("v%0d_ready", i),  bus.MC_Ready, vt[i].exp_ready);
            check($sformatf("v%0d_hazard", i), bus.ID_PendHazard, vt[i].exp_haz);
            if (vt[i].exp_we) exp_q.push_back({vt[i].exp_addr, vt[i].exp_data});
            @(negedge clock);
            check($sformatf("v%0d_count", i),  bus.Q_Count, vt[i].exp_count);
        end

        // Starvation: WB writes every cycle while Rd=9 waits at the head.
        drive(1, 7, 32'h700, 1, 9, 32'h900, 0, 0);
        #1 exp_q.push_back({5'd7, 32'h700});
        @(negedge clock);
        for (int k = 1; k <= 10; k++) begin
            drive(1, 7, 32'h700 + k, 0, 0, 0, 0, 0);
            #1 exp_q.push_back({5'd7, 32'h700 + k});
            @(negedge clock);
            check($sformatf("starve_hold_%0d", k), bus.Pipe_Hold, (k >= 8));
        end
        drive(0, 0, 0, 0, 0, 0, 9, 0);
        #1;
        check("hold_during_grant", bus.Pipe_Hold, 1);
        check("hazard_starved", bus.ID_PendHazard, 1);
        exp_q.push_back({5'd9, 32'h900});
        @(negedge clock);
        check("hold_after_grant", bus.Pipe_Hold, 0);
        check("count_after_grant", bus.Q_Count, 0);

        // Reset with three queued entries and Pipe_Hold asserted.
        for (int k = 0; k < 13; k++) begin
            if (k < 3) drive(1, 7, 32'h7A0 + k, 1, 5'(10 + k), 32'hA00 + k, 0, 0);
            else       drive(1, 7, 32'h7A0 + k, 0, 0, 0, 0, 0);
            #1 exp_q.push_back({5'd7, 32'h7A0 + k});
            @(negedge clock);
        end
        check("pre_rst_hold",  bus.Pipe_Hold, 1);
        check("pre_rst_count", bus.Q_Count, 3);
        drive(0, 0, 0, 0, 0, 0, 10, 0);
        #1 check("pre_rst_hazard", bus.ID_PendHazard, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_we",     bus.RF_WE, 0);
        check("async_rst_addr",   bus.RF_Addr, 0);
        check("async_rst_data",   bus.RF_Data, 0);
        check("async_rst_count",  bus.Q_Count, 0);
        check("async_rst_hold",   bus.Pipe_Hold, 0);
        check("async_rst_hazard", bus.ID_PendHazard, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("post_rst_count", bus.Q_Count, 0);
        check("post_rst_we",    bus.RF_WE, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port.
- Two sources compete for it: the pipeline writeback from the MEM/WB register, and a small in-order queue of results from multi-cycle units (divider, uncached-load return).
- Pipeline writeback always has priority; queued results drain in otherwise idle cycles.
- Provides a pending-write hazard flag for decode, and a hold request to the stall logic when a queued result starves.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive ungranted cycles with a valid head before Pipe_Hold asserts; range 1..255.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- WB_RegWrite  in  1  pipeline writeback request.
- WB_RtRd  in  5  pipeline destination register.
- WB_WriteData  in  32  pipeline writeback data (post MemtoReg mux).
- MC_Valid  in  1  multi-cycle result offered.
- MC_Rd  in  5  multi-cycle destination register.
- MC_Data  in  32  multi-cycle result data.
- MC_Ready  out  1  queue can accept; equals (Q_Count < DEPTH).
- ID_Rs  in  5  decode source register A.
- ID_Rt  in  5  decode source register B.
- ID_PendHazard  out  1  decode must stall; a queued write targets a source register.
- Pipe_Hold  out  1  registered request to stall logic to bubble WB.
- RF_WE  out  1  register-file write enable (registered).
- RF_Addr  out  5  register-file write address (registered).
- RF_Data  out  32  register-file write data (registered).
- Q_Count  out  $clog2(DEPTH)+1  number of occupied entries, live or killed.

Behaviour:
- Reset values (asynchronous): queue empty, all entry valid bits 0, starvation counter 0, Pipe_Hold 0, RF_WE 0, RF_Addr 0, RF_Data 0, Q_Count 0. Reset mid-operation discards all queued results.
- Grant, evaluated combinationally each cycle:
  - WB_grant = WB_RegWrite && WB_RtRd != 0.
  - Q_grant = !WB_grant && head occupied && head live.
  - Otherwise no write. WB_RegWrite with WB_RtRd = 0 counts as no request.
- Write port latency is 1 cycle. On posedge:
  - RF_WE <= WB_grant | Q_grant.
  - RF_Addr/RF_Data <= winner's address/data; they hold their previous values when no write.
- Enqueue: MC_Valid && MC_Ready pushes {MC_Rd, MC_Data, live = 1} at the tail.
  - MC_Rd = 0 is accepted (handshake completes) but not stored.
  - MC_Ready does not depend on a same-cycle pop: a full queue refuses even if the head drains this cycle.
- Pop: the head is popped when Q_grant, or when the head is occupied but killed.
  - A killed head pops with no write and does not block WB.
  - At most one pop per cycle.
- Kill (write-after-write ordering): on WB_grant to register X, every occupied entry with rd = X has its live bit cleared.
  - An entry being pushed in the same cycle is younger and is not killed.
- Simultaneous push and pop: both occur and Q_Count is unchanged. Pointers wrap modulo DEPTH.
- ID_PendHazard = 1 when:
  - any live entry matches a nonzero ID_Rs or ID_Rt, or
  - a same-cycle accepted push matches.
  - Register 0 never hazards. The flag is combinational.
- Starvation counter (8 bits, saturating):
  - Increments when the head is live and not granted.
  - Clears to 0 on Q_grant or when the head is not live/occupied.
  - Pipe_Hold <= (counter + increment >= STARVE_LIMIT) && head live; this is registered.
  - Pipe_Hold deasserts the cycle after the head is granted or killed.
- Stall logic responds to Pipe_Hold by masking WB_RegWrite. The arbiter keeps WB priority even while Pipe_Hold = 1.

Optional Feature:
- Macro WBARB_PERF_EN.
- When defined: adds outputs Perf_HoldCycles [31:0] and Perf_KillCount [31:0].
  - Perf_HoldCycles counts cycles with Pipe_Hold = 1.
  - Perf_KillCount counts entries whose live bit is cleared by a kill.
  - Both are wrapping counters, reset to 0.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Idle WB; push {Rd=5, 0xA5A5A5A5} -> next cycle queue holds it; following cycle RF_WE=1, RF_Addr=5, RF_Data=0xA5A5A5A5; Q_Count returns to 0.
- WB_RegWrite=1 every cycle, Rd=7; push Rd=9 -> queue never granted. Pipe_Hold rises once the counter reaches STARVE_LIMIT=8. Drop WB_RegWrite -> Rd=9 written next cycle; Pipe_Hold falls the cycle after the grant.
- Queue holds Rd=3; WB writes Rd=3 -> entry killed; ID_Rs=3 -> ID_PendHazard=0. Head pops without a write; the register file holds only the WB value.
- Push DEPTH=4 results, no drain -> MC_Ready=0 and Q_Count=4. A fifth MC_Valid is not accepted. Drain one -> MC_Ready=1 next cycle.
- Push Rd=0 -> MC_Ready handshake completes, Q_Count stays 0, no write. WB_RegWrite=1 with WB_RtRd=0 -> queue head granted instead.
- Assert reset asynchronously with 3 queued entries and Pipe_Hold=1 -> all outputs 0 immediately; no writes after deassertion.
